// File: rtl/sync_fifo.sv
// Single-clock FIFO with registered read data, occupancy count and threshold flags.
// Status flags are decoded directly from the registered count so they are valid out of reset.
module sync_fifo #(
  parameter int WIDTH    = 8,
  parameter int DEPTH    = 8,
  parameter int ADDRESS  = 3,
  parameter int AF_LEVEL = 6,
  parameter int AE_LEVEL = 2
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               w_inc,
  input  logic [WIDTH-1:0]   wr_data,
  input  logic               r_inc,
  input  logic               flush,
  output logic [WIDTH-1:0]   rd_data,
  output logic               rd_valid,
  output logic               full,
  output logic               empty,
  output logic               almost_full,
  output logic               almost_empty,
  output logic [ADDRESS:0]   count,
  output logic               overflow,
  output logic               underflow
);

  localparam int CW = ADDRESS + 1;
  localparam logic [ADDRESS:0] FULL_LVL = CW'(DEPTH);
  localparam logic [ADDRESS:0] AF_LVL   = CW'(AF_LEVEL);
  localparam logic [ADDRESS:0] AE_LVL   = CW'(AE_LEVEL);
  localparam logic [ADDRESS:0] ONE      = CW'(1);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [ADDRESS:0] wr_ptr;
  logic [ADDRESS:0] rd_ptr;
  logic             wr_ok;
  logic             rd_ok;
  logic [ADDRESS:0] count_nxt;

  assign full         = (count == FULL_LVL);
  assign empty        = (count == '0);
  assign almost_full  = (count >= AF_LVL);
  assign almost_empty = (count <= AE_LVL);

  // rst gating keeps the memory from being written while reset is still held
  assign wr_ok = rst & w_inc & ~full  & ~flush;
  assign rd_ok = rst & r_inc & ~empty & ~flush;

  always_comb begin
    count_nxt = count;
    if (flush) begin
      count_nxt = '0;
    end else begin
      case ({wr_ok, rd_ok})
        2'b10:   count_nxt = count + ONE;
        2'b01:   count_nxt = count - ONE;
        default: count_nxt = count;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_ptr    <= '0;
      rd_ptr    <= '0;
      count     <= '0;
      rd_data   <= '0;
      rd_valid  <= 1'b0;
      overflow  <= 1'b0;
      underflow <= 1'b0;
    end else begin
      count     <= count_nxt;
      rd_valid  <= rd_ok;
      overflow  <= w_inc & full  & ~flush;
      underflow <= r_inc & empty & ~flush;
      if (flush) begin
        wr_ptr <= '0;
        rd_ptr <= '0;
      end else begin
        if (wr_ok) wr_ptr <= wr_ptr + ONE;
        if (rd_ok) begin
          rd_ptr  <= rd_ptr + ONE;
          rd_data <= mem[rd_ptr[ADDRESS-1:0]];
        end
      end
    end
  end

  // Storage carries no reset so it can map onto RAM
  always_ff @(posedge clk) begin
    if (wr_ok) mem[wr_ptr[ADDRESS-1:0]] <= wr_data;
  end

endmodule

// File: tb/tb_sync_fifo.sv
// Scoreboard bench for sync_fifo: stimulus pushes expected read words, a monitor checks them.
module tb_sync_fifo;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       w_inc = 1'b0;
  logic [7:0] wr_data = '0;
  logic       r_inc = 1'b0;
  logic       flush = 1'b0;
  logic [7:0] rd_data;
  logic       rd_valid;
  logic       full, empty, almost_full, almost_empty;
  logic [3:0] count;
  logic       overflow, underflow;

  int n_cmp = 0;
  int n_err = 0;

  logic [7:0] exp_q[$];
  logic [7:0] mdata[$];
  logic [7:0] last_rd = 8'h00;

  sync_fifo #(.WIDTH(8), .DEPTH(8), .ADDRESS(3), .AF_LEVEL(6), .AE_LEVEL(2)) dut (
    .clk(clk), .rst(rst), .w_inc(w_inc), .wr_data(wr_data), .r_inc(r_inc),
    .flush(flush), .rd_data(rd_data), .rd_valid(rd_valid), .full(full),
    .empty(empty), .almost_full(almost_full), .almost_empty(almost_empty),
    .count(count), .overflow(overflow), .underflow(underflow)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic check_flags(input string tag);
    int c;
    c = mdata.size();
    check({tag, ".count"}, 32'(count), 32'(c));
    check({tag, ".full"}, 32'(full), 32'(c == 8));
    check({tag, ".empty"}, 32'(empty), 32'(c == 0));
    check({tag, ".almost_full"}, 32'(almost_full), 32'(c >= 6));
    check({tag, ".almost_empty"}, 32'(almost_empty), 32'(c <= 2));
  endtask

  // One clock of stimulus; the bench model decides what should be accepted
  task automatic step(input string tag, input logic w, input logic [7:0] d,
                      input logic r, input logic f);
    logic wacc, racc, eovf, eudf;
    int c;
    @(negedge clk);
    w_inc = w; wr_data = d; r_inc = r; flush = f;
    c = mdata.size();
    wacc = w && c < 8 && !f;
    racc = r && c > 0 && !f;
    eovf = w && c == 8 && !f;
    eudf = r && c == 0 && !f;
    if (racc) begin
      last_rd = mdata.pop_front();
      exp_q.push_back(last_rd);
    end
    if (wacc) mdata.push_back(d);
    if (f) mdata.delete();
    @(posedge clk);
    #1;
    w_inc = 1'b0; r_inc = 1'b0; flush = 1'b0;
    check({tag, ".overflow"}, 32'(overflow), 32'(eovf));
    check({tag, ".underflow"}, 32'(underflow), 32'(eudf));
    check({tag, ".rd_valid"}, 32'(rd_valid), 32'(racc));
    check_flags(tag);
  endtask

  always @(negedge clk) begin
    if (rst && rd_valid) begin
      if (exp_q.size() == 0) begin
        n_cmp++;
        n_err++;
        $display("FAIL rd_unexpected: got rd_valid=1 data 0x%0h, expected no read at %0t", rd_data, $time);
      end else begin
        check("rd_data", 32'(rd_data), 32'(exp_q.pop_front()));
      end
    end
  end

  initial begin
    // Reset state
    #2;
    check_flags("reset");
    check("reset.rd_data", 32'(rd_data), 32'h00);
    check("reset.rd_valid", 32'(rd_valid), 32'h0);
    check("reset.overflow", 32'(overflow), 32'h0);
    check("reset.underflow", 32'(underflow), 32'h0);
    @(negedge clk);
    rst = 1'b1;

    // Fill with squares, then one write too many
    for (int i = 0; i < 8; i++) step("fill", 1'b1, 8'(i * i), 1'b0, 1'b0);
    check("fill.af_at_8", 32'(almost_full), 32'h1);
    step("wr_full", 1'b1, 8'hFF, 1'b0, 1'b0);
    step("after_ovf", 1'b0, 8'h00, 1'b0, 1'b0);

    // Drain, then one read too many
    for (int i = 0; i < 8; i++) step("drain", 1'b0, 8'h00, 1'b1, 1'b0);
    step("idle", 1'b0, 8'h00, 1'b0, 1'b0);
    step("rd_empty", 1'b0, 8'h00, 1'b1, 1'b0);
    step("after_udf", 1'b0, 8'h00, 1'b0, 1'b0);
    check("rd_hold", 32'(rd_data), 32'd49);

    // Simultaneous traffic at mid, full and empty occupancy
    for (int i = 0; i < 4; i++) step("pre4", 1'b1, 8'hA0 + 8'(i), 1'b0, 1'b0);
    for (int i = 0; i < 3; i++) step("both_mid", 1'b1, 8'hB0 + 8'(i), 1'b1, 1'b0);
    for (int i = 0; i < 4; i++) step("to_full", 1'b1, 8'hC0 + 8'(i), 1'b0, 1'b0);
    step("both_full", 1'b1, 8'hEE, 1'b1, 1'b0);
    check("both_full.count7", 32'(count), 32'd7);
    for (int i = 0; i < 7; i++) step("drain2", 1'b0, 8'h00, 1'b1, 1'b0);
    step("both_empty", 1'b1, 8'h5A, 1'b1, 1'b0);
    check("both_empty.count1", 32'(count), 32'd1);
    step("drain3", 1'b0, 8'h00, 1'b1, 1'b0);

    // Interleaved pairs across pointer wrap
    for (int i = 0; i < 20; i++) begin
      step("pair_w", 1'b1, 8'(i), 1'b0, 1'b0);
      step("pair_r", 1'b0, 8'h00, 1'b1, 1'b0);
      check("pair.count_le8", 32'(count <= 4'd8), 32'h1);
    end

    // Flush wins over a write and holds rd_data
    for (int i = 0; i < 5; i++) step("pre_flush", 1'b1, 8'h70 + 8'(i), 1'b0, 1'b0);
    step("flush", 1'b1, 8'h99, 1'b0, 1'b1);
    check("flush.rd_data_hold", 32'(rd_data), 32'(last_rd));
    step("post_flush", 1'b0, 8'h00, 1'b1, 1'b0);

    // Asynchronous reset mid-operation with a write held during reset
    for (int i = 0; i < 3; i++) step("pre_rst", 1'b1, 8'h30 + 8'(i), 1'b0, 1'b0);
    step("pre_rst_idle", 1'b0, 8'h00, 1'b0, 1'b0);
    #2;
    rst = 1'b0;
    mdata.delete();
    #1;
    check_flags("async_rst");
    w_inc = 1'b1; wr_data = 8'h44;
    @(posedge clk);
    #1;
    check("rst_held.count", 32'(count), 32'd0);
    @(negedge clk);
    w_inc = 1'b0;
    rst = 1'b1;
    step("after_rst_rd", 1'b0, 8'h00, 1'b1, 1'b0);
    step("after_rst_w", 1'b1, 8'h55, 1'b0, 1'b0);
    step("after_rst_r", 1'b0, 8'h00, 1'b1, 1'b0);
    step("final_idle", 1'b0, 8'h00, 1'b0, 1'b0);

    check("scoreboard_drained", 32'(exp_q.size()), 32'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
